r2r_wavegen: RTL and testbench

Parametrised sample source for an R2R resistor-ladder DAC. It generalises the fixed 8-bit divider-plus-external-data controller: sample width, divider width and table depth are parameters. On top of pass-through of external data it adds three self-running waveform modes: sawtooth, triangle, and playback of a user-loaded sample table. It sits between the digital input pins and the R2R ladder, driving the ladder's bit inputs directly.

---
 rtl/r2r_wavegen.sv | 137 +++++++++++++
 tb/tb_r2r_wavegen.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r2r_wavegen.sv
// rtl/r2r_wavegen.sv - R2R ladder sample source: external pass-through, sawtooth, triangle, table playback
module r2r_wavegen #(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 16,
    parameter int DEPTH     = 16,
    parameter int DIV_RESET = 999
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     data_in,
    input  logic [1:0]           mode_in,
    input  logic [DIV_WIDTH-1:0] div_in,
    input  logic                 load_divider,
    input  logic                 tbl_wr,
    input  logic                 tbl_clr,
    output logic [WIDTH-1:0]     r2r_out,
    output logic                 tick
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        MODE_EXT = 2'd0,
        MODE_SAW = 2'd1,
        MODE_TRI = 2'd2,
        MODE_TBL = 2'd3
    } mode_t;

    mode_t                mode_q;
    logic [DIV_WIDTH-1:0] div;
    logic [DIV_WIDTH-1:0] cnt;
    logic [WIDTH-1:0]     idx;
    logic                 dir_down;
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        wr_ptr;
    logic [WIDTH-1:0]     mem [DEPTH];

    logic                 mode_chg;
    logic                 cnt_hit;
    logic                 tc;
    logic [WIDTH-1:0]     tri_next;
    logic [AW-1:0]        rd_next;

    // A mode change or divider load restarts the period, so it suppresses that cycle's terminal count.
    always_comb begin
        mode_chg = (mode_in != mode_q);
        cnt_hit  = (cnt == div);
        tc       = cnt_hit && !load_divider && !mode_chg;
        tri_next = dir_down ? (idx - 1'b1) : (idx + 1'b1);
        rd_next  = rd_ptr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r2r_out  <= '0;
            tick     <= 1'b0;
            div      <= DIV_WIDTH'(DIV_RESET);
            cnt      <= '0;
            idx      <= '0;
            dir_down <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            mode_q   <= MODE_EXT;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            tick <= tc;

            if (load_divider) begin
                div <= div_in;
            end

            if (load_divider || mode_chg || cnt_hit) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // Table reads below see the pre-write contents, so a same-entry read returns the old value.
            if (tbl_wr) begin
                mem[wr_ptr] <= data_in;
            end
            if (tbl_clr) begin
                wr_ptr <= '0;
            end else if (tbl_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (mode_chg) begin
                mode_q   <= mode_t'(mode_in);
                idx      <= '0;
                dir_down <= 1'b0;
                rd_ptr   <= '0;
                case (mode_in)
                    2'd0:    r2r_out <= data_in;
                    2'd3:    r2r_out <= mem[0];
                    default: r2r_out <= '0;
                endcase
            end else begin
                case (mode_q)
                    MODE_EXT: begin
                        r2r_out <= data_in;
                    end
                    MODE_SAW: begin
                        if (tc) begin
                            idx     <= idx + 1'b1;
                            r2r_out <= idx + 1'b1;
                        end
                    end
                    MODE_TRI: begin
                        // Direction flips on the same edge the endpoint is written, so endpoints never repeat.
                        if (tc) begin
                            idx     <= tri_next;
                            r2r_out <= tri_next;
                            if (tri_next == '1) begin
                                dir_down <= 1'b1;
                            end else if (tri_next == '0) begin
                                dir_down <= 1'b0;
                            end
                        end
                    end
                    MODE_TBL: begin
                        if (tc) begin
                            rd_ptr  <= rd_next;
                            r2r_out <= mem[rd_next];
                        end
                    end
                    default: begin
                        r2r_out <= r2r_out;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_r2r_wavegen.sv
// tb/tb_r2r_wavegen.sv - self-checking bench for r2r_wavegen
module tb_r2r_wavegen;

    logic        clk;
    logic        rst;
    logic [7:0]  data_in;
    logic [1:0]  mode_in;
    logic [15:0] div_in;
    logic        load_divider;
    logic        tbl_wr;
    logic        tbl_clr;
    logic [7:0]  r2r_out;
    logic        tick;

    int          checks;
    int          errors;
    logic [7:0]  exp_q[$];

    r2r_wavegen #(
        .WIDTH(8),
        .DIV_WIDTH(16),
        .DEPTH(16),
        .DIV_RESET(999)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .mode_in(mode_in),
        .div_in(div_in),
        .load_divider(load_divider),
        .tbl_wr(tbl_wr),
        .tbl_clr(tbl_clr),
        .r2r_out(r2r_out),
        .tick(tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in      = 8'($urandom);
            mode_in      = 2'($urandom);
            div_in       = 16'($urandom);
            load_divider = 1'($urandom);
            tbl_wr       = 1'($urandom);
            tbl_clr      = 1'($urandom);
            step();
            checks++;
            if (r2r_out !== 8'h00 || tick !== 1'b0) begin
                errors++;
                $display("FAIL reset_state r2r_out=%0h tick=%0b want 0/0", r2r_out, tick);
            end
        end
        rst = 1'b0; mode_in = 2'd0; data_in = 8'hA5;
        load_divider = 1'b0; tbl_wr = 1'b0; tbl_clr = 1'b0; div_in = '0;
        step();
        checks++;
        if (r2r_out !== 8'hA5) begin
            errors++;
            $display("FAIL ext_latency r2r_out=%0h want a5", r2r_out);
        end
        begin
            int n;
            n = 1;
            while (tick !== 1'b1 && n < 1100) begin
                step();
                n++;
            end
            checks++;
            if (tick !== 1'b1 || n != 1000) begin
                errors++;
                $display("FAIL first_tick edge=%0d tick=%0b want edge 1000", n, tick);
            end
        end
    endtask

    task automatic test_sawtooth();
        mode_in = 2'd1; load_divider = 1'b1; div_in = 16'd0;
        step();
        load_divider = 1'b0;
        checks++;
        if (r2r_out !== 8'h00) begin
            errors++;
            $display("FAIL saw_start r2r_out=%0h want 0", r2r_out);
        end
        for (int k = 1; k <= 257; k++) exp_q.push_back(8'(k));
        for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
            logic [7:0] e;
            step();
            checks++;
            if (tick !== 1'b1) begin
                errors++;
                $display("FAIL saw_tick cycle=%0d tick=%0b want 1", c, tick);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (r2r_out !== e) begin
                    errors++;
                    $display("FAIL saw_value r2r_out=%0h want %0h", r2r_out, e);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL saw_timeout left=%0d want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_triangle();
        int since;
        mode_in = 2'd2; load_divider = 1'b1; div_in = 16'd2;
        step();
        load_divider = 1'b0;
        checks++;
        if (r2r_out !== 8'h00) begin
            errors++;
            $display("FAIL tri_start r2r_out=%0h want 0", r2r_out);
        end
        for (int k = 1; k <= 515; k++) begin
            int m;
            m = k % 510;
            exp_q.push_back((m <= 255) ? 8'(m) : 8'(510 - m));
        end
        since = 0;
        for (int c = 0; c < 1700 && exp_q.size() > 0; c++) begin
            logic [7:0] e;
            step();
            since++;
            if (tick === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (r2r_out !== e || since != 3) begin
                    errors++;
                    $display("FAIL tri_sample r2r_out=%0h gap=%0d want %0h gap 3", r2r_out, since, e);
                end
                since = 0;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL tri_timeout left=%0d want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_table();
        int since;
        tbl_clr = 1'b1;
        step();
        tbl_clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tbl_wr  = 1'b1;
            data_in = 8'(8'h10 + i);
            step();
        end
        tbl_wr = 1'b0;
        mode_in = 2'd3; load_divider = 1'b1; div_in = 16'd1;
        step();
        load_divider = 1'b0;
        checks++;
        if (r2r_out !== 8'h10) begin
            errors++;
            $display("FAIL tbl_start r2r_out=%0h want 10", r2r_out);
        end
        tbl_wr = 1'b1; data_in = 8'h77;
        step();
        tbl_wr = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            exp_q.push_back(((k % 16) == 0) ? 8'h77 : 8'(8'h10 + (k % 16)));
        end
        since = 1;
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
            logic [7:0] e;
            step();
            since++;
            if (tick === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (r2r_out !== e || since != 2) begin
                    errors++;
                    $display("FAIL tbl_sample r2r_out=%0h gap=%0d want %0h gap 2", r2r_out, since, e);
                end
                since = 0;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL tbl_timeout left=%0d want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_disturb();
        mode_in = 2'd1; load_divider = 1'b1; div_in = 16'd5;
        step();
        load_divider = 1'b0;
        step();
        step();
        mode_in = 2'd3;
        step();
        checks++;
        if (r2r_out !== 8'h77 || tick !== 1'b0) begin
            errors++;
            $display("FAIL switch_1_to_3 r2r_out=%0h tick=%0b want 77/0", r2r_out, tick);
        end
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if ((k < 6 && tick !== 1'b0) || (k == 6 && (tick !== 1'b1 || r2r_out !== 8'h11))) begin
                errors++;
                $display("FAIL restart_period edge=%0d tick=%0b r2r_out=%0h want tick at 6 with 11", k, tick, r2r_out);
            end
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (tick !== 1'b0) begin
                errors++;
                $display("FAIL pre_load_tick edge=%0d tick=%0b want 0", k, tick);
            end
        end
        load_divider = 1'b1; div_in = 16'd2;
        step();
        load_divider = 1'b0;
        checks++;
        if (tick !== 1'b0 || r2r_out !== 8'h11) begin
            errors++;
            $display("FAIL load_at_tc tick=%0b r2r_out=%0h want 0/11", tick, r2r_out);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if ((k < 3 && tick !== 1'b0) || (k == 3 && (tick !== 1'b1 || r2r_out !== 8'h12))) begin
                errors++;
                $display("FAIL new_period edge=%0d tick=%0b r2r_out=%0h want tick at 3 with 12", k, tick, r2r_out);
            end
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (r2r_out !== 8'h00 || tick !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset r2r_out=%0h tick=%0b want 0/0", r2r_out, tick);
        end
        mode_in = 2'd3; load_divider = 1'b1; div_in = 16'd0;
        tbl_wr = 1'b1; data_in = 8'h5A;
        step();
        load_divider = 1'b0; tbl_wr = 1'b0;
        checks++;
        if (r2r_out !== 8'h00) begin
            errors++;
            $display("FAIL same_entry_old r2r_out=%0h want 0", r2r_out);
        end
        for (int k = 1; k <= 16; k++) exp_q.push_back((k == 16) ? 8'h5A : 8'h00);
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            logic [7:0] e;
            step();
            if (tick === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (r2r_out !== e) begin
                    errors++;
                    $display("FAIL cleared_table r2r_out=%0h want %0h", r2r_out, e);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL cleared_timeout left=%0d want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; data_in = '0; mode_in = '0; div_in = '0;
        load_divider = 1'b0; tbl_wr = 1'b0; tbl_clr = 1'b0;
        test_reset();
        test_sawtooth();
        test_triangle();
        test_table();
        test_disturb();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
